// File: rtl/spam_timer_pkg.sv
// spam_timer shared definitions
// SPAM bus widths, register offsets and CTRL bit positions
package spam_timer_pkg;

  localparam int SPAM_ADDR_HI = 31;
  localparam int SPAM_DATA_HI = 31;
  localparam int SPAM_DID_HI  = 3;

  localparam logic [7:0] TMR_OFF_CTRL     = 8'h00;
  localparam logic [7:0] TMR_OFF_PRESCALE = 8'h04;
  localparam logic [7:0] TMR_OFF_COUNT    = 8'h08;
  localparam logic [7:0] TMR_OFF_COMPARE  = 8'h0C;
  localparam logic [7:0] TMR_OFF_STATUS   = 8'h10;
  localparam logic [7:0] TMR_OFF_SNAP     = 8'h14;

  localparam int TMR_CTRL_EN     = 0;
  localparam int TMR_CTRL_AR     = 1;
  localparam int TMR_CTRL_IRQ_EN = 2;

  localparam logic [31:0] TMR_COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_PRESCALE,
    REG_COUNT,
    REG_COMPARE,
    REG_STATUS,
    REG_SNAP,
    REG_NONE
  } tmr_reg_e;

  // Word offset to register select; byte lane bits are ignored
  function automatic tmr_reg_e tmr_decode(input logic [7:0] off);
    tmr_reg_e sel;
    case (off[7:2])
      6'h00:   sel = REG_CTRL;
      6'h01:   sel = REG_PRESCALE;
      6'h02:   sel = REG_COUNT;
      6'h03:   sel = REG_COMPARE;
      6'h04:   sel = REG_STATUS;
      6'h05:   sel = REG_SNAP;
      default: sel = REG_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/spam_timer_tick.sv
// spam_timer prescaler
// Emits one tick every prescale+1 cycles while enabled
module spam_timer_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_prescale,
  input  logic        i_clear,
  output logic        o_tick
);

  logic [15:0] r_pcnt;

  assign o_tick = i_en && (r_pcnt == i_prescale);

  // Prescale counter, held at zero while disabled or on reconfiguration
  always_ff @(posedge clk) begin
    if (rst || i_clear || !i_en) begin
      r_pcnt <= '0;
    end else if (o_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/spam_timer.sv
// spam_timer top
// SPAM-mapped 32-bit timer with compare, autoreload and level irq
module spam_timer
  import spam_timer_pkg::*;
#(
  parameter logic [SPAM_ADDR_HI:0] TMR_BASE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spamo_valid,
  input  logic                  spamo_r_nw,
  input  logic [SPAM_DID_HI:0]  spamo_did,
  input  logic [SPAM_ADDR_HI:0] spamo_addr,
  input  logic [SPAM_DATA_HI:0] spamo_data,
  output logic                  tmr__spami_busy_b,
  output logic [SPAM_DATA_HI:0] tmr__spami_data,
  output logic                  tmr_irq
);

  logic [2:0]            r_ctrl;
  logic [15:0]           r_prescale;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_match;
  logic [31:0]           r_snap;
  logic                  r_busy;
  logic [SPAM_DATA_HI:0] r_data;
  logic                  r_irq;

  logic                  w_hit;
  logic                  w_rd;
  logic                  w_wr;
  tmr_reg_e              w_sel;
  logic                  w_wr_ctrl;
  logic                  w_wr_pre;
  logic                  w_wr_cnt;
  logic                  w_wr_cmp;
  logic                  w_wr_sts;
  logic                  w_rd_snap;
  logic                  w_tick;
  logic                  w_cnt_eq;
  logic [SPAM_DATA_HI:0] w_rdata;
  logic                  w_unused;

  assign w_hit = spamo_valid &&
    (spamo_addr[SPAM_ADDR_HI:8] == TMR_BASE[SPAM_ADDR_HI:8]);
  assign w_rd  = w_hit && spamo_r_nw;
  assign w_wr  = w_hit && !spamo_r_nw;
  assign w_sel = tmr_decode(spamo_addr[7:0]);

  assign w_wr_ctrl = w_wr && (w_sel == REG_CTRL);
  assign w_wr_pre  = w_wr && (w_sel == REG_PRESCALE);
  assign w_wr_cnt  = w_wr && (w_sel == REG_COUNT);
  assign w_wr_cmp  = w_wr && (w_sel == REG_COMPARE);
  assign w_wr_sts  = w_wr && (w_sel == REG_STATUS);
  assign w_rd_snap = w_rd && (w_sel == REG_SNAP);

  assign w_cnt_eq = (r_count == r_compare);

  // Requester ID, byte lanes and the snapshot latch are not observable
  assign w_unused = ^{spamo_did, spamo_addr[1:0], r_snap};

  spam_timer_tick u_tick (
    .clk        (clk),
    .rst        (rst),
    .i_en       (r_ctrl[TMR_CTRL_EN]),
    .i_prescale (r_prescale),
    .i_clear    (w_wr_ctrl || w_wr_pre),
    .o_tick     (w_tick)
  );

  // Read mux over pre-update register values
  always_comb begin
    w_rdata = '0;
    unique case (w_sel)
      REG_CTRL:     w_rdata = {29'd0, r_ctrl};
      REG_PRESCALE: w_rdata = {16'd0, r_prescale};
      REG_COUNT:    w_rdata = r_count;
      REG_COMPARE:  w_rdata = r_compare;
      REG_STATUS:   w_rdata = {31'd0, r_match};
      REG_SNAP:     w_rdata = r_count;
      default:      w_rdata = '0;
    endcase
  end

  // Software-written configuration registers and snapshot latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_compare  <= TMR_COMPARE_RST;
      r_snap     <= '0;
    end else begin
      if (w_wr_ctrl) r_ctrl <= spamo_data[2:0];
      if (w_wr_pre) r_prescale <= spamo_data[15:0];
      if (w_wr_cmp) r_compare <= spamo_data;
      if (w_rd_snap) r_snap <= r_count;
    end
  end

  // Counter and sticky match; software COUNT write beats a tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_match <= 1'b0;
    end else begin
      if (w_wr_cnt) begin
        r_count <= spamo_data;
      end else if (w_tick) begin
        if (w_cnt_eq && r_ctrl[TMR_CTRL_AR]) r_count <= '0;
        else r_count <= r_count + 32'd1;
      end
      if (w_tick && !w_wr_cnt && w_cnt_eq) begin
        r_match <= 1'b1;
      end else if (w_wr_sts && spamo_data[0]) begin
        r_match <= 1'b0;
      end
    end
  end

  // One-cycle response strobe, data zeroed unless returning a read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_data <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_busy <= w_hit;
      r_data <= w_rd ? w_rdata : '0;
      r_irq  <= r_match && r_ctrl[TMR_CTRL_IRQ_EN];
    end
  end

  assign tmr__spami_busy_b = r_busy;
  assign tmr__spami_data   = r_data;
  assign tmr_irq           = r_irq;

endmodule

// File: doc/spam_timer.md
# spam_timer

Memory-mapped timer peripheral on the SPAM bus, alongside the console and LCD devices. It consumes the core's `spamo_*` request stream and produces its own `tmr__spami_busy_b` and `tmr__spami_data` response pair. The system OR-merges this pair into `spami_busy_b` and `spami_data`. It provides a prescaled 32-bit up-counter, a compare register with a sticky match flag, optional auto-reload, and a level interrupt output.

## Interface
Parameters:
- `TMR_BASE`, default 0, SPAM address of the register window; bits [7:0] must be zero.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `spamo_valid`  in  1  request strobe.
- `spamo_r_nw`  in  1  1 = read, 0 = write.
- `spamo_did`  in  SPAM_DID_HI+1  requester ID; ignored.
- `spamo_addr`  in  SPAM_ADDR_HI+1  byte address.
- `spamo_data`  in  SPAM_DATA_HI+1 (32)  write data.
- `tmr__spami_busy_b`  out  1  one-cycle response strobe; 0 when idle.
- `tmr__spami_data`  out  SPAM_DATA_HI+1  read data; all-zero when not responding (required for OR-merge).
- `tmr_irq`  out  1  STATUS.match AND CTRL.irq_en.

## Operation
- Hit condition:
  - `spamo_valid` and `spamo_addr[SPAM_ADDR_HI:8] == TMR_BASE[SPAM_ADDR_HI:8]`.
  - Offset is `addr[7:0]`; `addr[1:0]` is ignored.
- Registers (all values are reset values):
  - 0x00 CTRL, reset 0: bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
  - 0x04 PRESCALE, reset 0, 16 bits: one tick every PRESCALE+1 cycles.
  - 0x08 COUNT, reset 0, R/W.
  - 0x0C COMPARE, reset 0xFFFFFFFF, R/W.
  - 0x10 STATUS, reset 0: bit0 match, sticky, write-1-to-clear.
  - 0x14 SNAP: read returns COUNT and also latches it into the SNAP register; writes are ignored.
  - Other offsets: reads return 0, writes are ignored, and a response is still given.
- Prescaler:
  - `pcnt` is 16 bits and is held at 0 while en=0.
  - While en=1, a tick occurs when `pcnt == PRESCALE`; `pcnt` then returns to 0, otherwise it increments.
  - Writing PRESCALE or CTRL clears `pcnt`.
- On tick:
  - If `COUNT == COMPARE`: set match. With autoreload=1, COUNT <= 0; otherwise COUNT <= COUNT+1.
  - Else COUNT <= COUNT+1, wrapping 0xFFFFFFFF -> 0 without setting any flag.
- Simultaneous events:
  - A software write to COUNT in a tick cycle wins; that tick's increment and match check are dropped.
  - A STATUS W1C in the same cycle as a new match leaves match=1 (set wins).
  - A COMPARE write in a tick cycle: the match check uses the old COMPARE.
- No back-pressure. Every hit is accepted, including back-to-back hits on consecutive cycles.

## Timing
- Response latency is exactly 1 cycle:
  - A hit in cycle N gives `tmr__spami_busy_b` = 1 in cycle N+1 only.
  - Reads return the register value sampled at the end of cycle N, before that cycle's updates.
  - Writes take effect at the end of cycle N and return zero data.
- All outputs are registered. `tmr_irq` follows STATUS/CTRL with 1 cycle delay after the register update.
- Reset:
  - All registers take their listed reset values; `pcnt` = 0.
  - `tmr__spami_busy_b` = 0, `tmr__spami_data` = 0, `tmr_irq` = 0.
  - A response pending when `rst` is asserted is dropped.
  - Requests in reset cycles are not accepted.
- PRESCALE = 0 gives a tick every cycle while en=1.
- Clearing en freezes COUNT and clears `pcnt` on the next edge.

## Structure
- Shared package/defines:
  - SPAM widths (SPAM_ADDR_HI, SPAM_DATA_HI, SPAM_DID_HI) come from the existing SPAM defines.
  - Add TMR_OFF_CTRL/PRESCALE/COUNT/COMPARE/STATUS/SNAP offset constants and CTRL bit indices there, for software headers and the bench.
- Sub-module `spam_timer_tick`: prescaler counter (en, prescale, clear -> tick).
- Top-level contents: decode, register file, counter/match logic, response register. Approximately 150–250 lines.

## Test plan
- Reset then read every offset:
  - CTRL, PRESCALE, COUNT, STATUS, SNAP read 0; COMPARE reads 0xFFFFFFFF.
  - `busy_b` pulses exactly 1 cycle after each request; data is 0 in all other cycles.
- PRESCALE=3, COUNT=0, en=1, run 40 cycles:
  - COUNT reads 10 ±1 with exact tick spacing of 4 cycles; pause with en=0 and confirm COUNT holds.
- COMPARE=5, autoreload=1, irq_en=1, PRESCALE=0:
  - match and `tmr_irq` assert 1 cycle after the COUNT==5 tick; COUNT then reads 0, 1, ...
  - W1C of STATUS clears `tmr_irq` next cycle.
- COUNT=0xFFFFFFFE, COMPARE=0, autoreload=0, PRESCALE=0:
  - wraps to 0 with no match, then match sets at the following tick (COUNT 0 == COMPARE 0).
- Collisions:
  - Write COUNT=100 on a tick cycle: next read is 100.
  - W1C STATUS in the same cycle as a match: match stays 1.
- Window and decode:
  - Back-to-back reads on 3 consecutive cycles give 3 consecutive responses.
  - A request to TMR_BASE+0x100 gives no response.
  - Offset 0x20 returns 0 with a response.
  - Assert `rst` the cycle after a hit: no response appears.
